// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
package seg_pkg;

  localparam int unsigned SEG_MAX_DIGITS = 8;
  localparam logic [7:0]  ANODE_ALL_OFF  = 8'hFF;
  localparam int unsigned DIGIT_IDX_W    = 3;

  typedef logic [DIGIT_IDX_W-1:0] digit_idx_t;

  // Per-slot anode phase: all anodes dark first, then the selected digit driven.
  typedef enum logic {
    SLOT_BLANK,
    SLOT_DRIVE
  } slot_state_t;

  // Nibble of a 32-bit value at digit position idx.
  function automatic logic [3:0] get_nibble(input logic [31:0] value, input digit_idx_t idx);
    return value[{idx, 2'b00} +: 4];
  endfunction

  // True when every displayed nibble at positions >= idx is zero.
  function automatic logic upper_zero(input logic [31:0] value, input digit_idx_t idx,
                                      input int unsigned ndig);
    logic z;
    z = 1'b1;
    for (int unsigned i = 0; i < SEG_MAX_DIGITS; i++) begin
      if ((i >= 32'(idx)) && (i < ndig) && (value[4*i +: 4] != 4'h0)) z = 1'b0;
    end
    return z;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_clk_prescaler.sv
// Free-running divider: counts 0..DIV-1 and flags the terminal count.
module clk_prescaler #(
  parameter int unsigned DIV = 4,
  parameter int unsigned CW  = $clog2(DIV)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wrap to zero after the terminal value.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tc_o) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tc_o  = (cnt_q == CW'(DIV - 1));
  assign cnt_o = cnt_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit scan of a 32-bit value with frame-synchronous
// update, optional leading-zero blanking and inter-digit ghost blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 100000,
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned BLANK_CYC  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] disp_value,
  input  logic        load,
  input  logic        blank_lead,
  output logic [3:0]  reg_hex,
  output logic [7:0]  anode,
  output logic        slow_tick,
  output logic [2:0]  digit_idx
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] presc_cnt;
  logic          presc_tc;
  logic [CW:0]   presc_inc;

  slot_state_t state_q, state_d;
  digit_idx_t  digit_q, digit_d;
  logic [31:0] shown_q, shown_d;
  logic [31:0] pend_q, pend_d;
  logic        pvld_q, pvld_d;
  logic [3:0]  hex_q, hex_d;
  logic [7:0]  anode_q, anode_d;
  logic        tick_q, tick_d;
  logic        wrap;

  clk_prescaler #(
    .DIV (CLK_DIV),
    .CW  (CW)
  ) u_presc (
    .clk_i  (clk),
    .rst_ni (reset),
    .cnt_o  (presc_cnt),
    .tc_o   (presc_tc)
  );

  assign presc_inc = {1'b0, presc_cnt} + (CW+1)'(1);
  assign wrap      = presc_tc && (digit_q == digit_idx_t'(NUM_DIGITS - 1));

  // Slot phase FSM: dark for the first BLANK_CYC counts of each slot.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SLOT_BLANK: begin
        if (presc_tc ? (BLANK_CYC == 0) : (presc_inc >= (CW+1)'(BLANK_CYC)))
          state_d = SLOT_DRIVE;
      end
      SLOT_DRIVE: begin
        if (presc_tc && (BLANK_CYC > 0)) state_d = SLOT_BLANK;
      end
      default: state_d = SLOT_BLANK;
    endcase
  end

  // Digit advance, frame commit of pending value, and load capture.
  // Outputs are computed from next-state values so the registered
  // outputs line up with the counter/index they describe; the wrap
  // commit feeds reg_hex for digit 0 on the same edge.
  always_comb begin
    digit_d = digit_q;
    shown_d = shown_q;
    pend_d  = pend_q;
    pvld_d  = pvld_q;
    tick_d  = presc_tc;
    if (presc_tc) digit_d = wrap ? '0 : digit_q + digit_idx_t'(1);
    if (wrap && pvld_q) begin
      shown_d = pend_q;
      pvld_d  = 1'b0;
    end
    if (load) begin
      pend_d = disp_value;
      pvld_d = 1'b1;
    end
    hex_d = get_nibble(shown_d, digit_d);
  end

  // Anode select with ghost blanking and leading-zero suppression.
  always_comb begin
    anode_d = ANODE_ALL_OFF;
    if (state_d == SLOT_DRIVE) begin
      if (!(blank_lead && (digit_d != '0) && upper_zero(shown_d, digit_d, NUM_DIGITS)))
        anode_d = ~(8'h01 << digit_d);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SLOT_BLANK;
      digit_q <= '0;
      shown_q <= '0;
      pend_q  <= '0;
      pvld_q  <= 1'b0;
      hex_q   <= 4'h0;
      anode_q <= ANODE_ALL_OFF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      shown_q <= shown_d;
      pend_q  <= pend_d;
      pvld_q  <= pvld_d;
      hex_q   <= hex_d;
      anode_q <= anode_d;
      tick_q  <= tick_d;
    end
  end

  assign reg_hex   = hex_q;
  assign anode     = anode_q;
  assign slow_tick = tick_q;
  assign digit_idx = digit_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl against a cycle-count reference model.
module tb_seg_scan_ctrl;

  localparam int unsigned DIV = 4;
  localparam int unsigned BLK = 1;
  localparam int unsigned ND  = 8;
  localparam int unsigned FRAME = DIV * ND;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic        blank_lead = 1'b0;
  logic [31:0] disp_value = '0;
  logic [3:0]  reg_hex;
  logic [7:0]  anode;
  logic        slow_tick;
  logic [2:0]  digit_idx;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: edges since reset, displayed/pending values.
  int          m_cyc;
  logic [31:0] m_shown, m_pend;
  bit          m_pvld, m_bl;
  logic [15:0] act, expv;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .CLK_DIV    (DIV),
    .NUM_DIGITS (ND),
    .BLANK_CYC  (BLK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .disp_value (disp_value),
    .load       (load),
    .blank_lead (blank_lead),
    .reg_hex    (reg_hex),
    .anode      (anode),
    .slow_tick  (slow_tick),
    .digit_idx  (digit_idx)
  );

  // Expected {reg_hex, anode, slow_tick, digit_idx} from slot arithmetic.
  function automatic logic [15:0] exp_out();
    int unsigned presc, dig;
    logic [63:0] hi;
    logic [7:0]  an;
    logic [2:0]  d3;
    presc = m_cyc % DIV;
    dig   = (m_cyc / DIV) % ND;
    hi    = {32'h0, m_shown} >> (4 * dig);
    an    = 8'hFF;
    if (presc >= BLK && !(m_bl && dig != 0 && hi == 64'h0)) an[dig] = 1'b0;
    d3 = dig[2:0];
    return {hi[3:0], an, (m_cyc != 0 && presc == 0), d3};
  endfunction

  function automatic int unsigned m_dig();
    return (m_cyc / DIV) % ND;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_shown = '0; m_pend = '0; m_pvld = 0; m_bl = 0;
  endtask

  // One clock: advance the model with the inputs the DUT sees at this edge.
  task automatic cycle();
    @(posedge clk);
    m_cyc++;
    if ((m_cyc % FRAME) == 0 && m_pvld) begin
      m_shown = m_pend;
      m_pvld  = 0;
    end
    if (load) begin
      m_pend = disp_value;
      m_pvld = 1;
    end
    m_bl = blank_lead;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    act = {reg_hex, anode, slow_tick, digit_idx};
    n_checks++;
    if (act !== {4'h0, 8'hFF, 1'b0, 3'd0}) begin
      n_fail++; $display("FAIL reset_hold got=%h want=%h", act, {4'h0, 8'hFF, 1'b0, 3'd0});
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    n_checks++;
    if ({reg_hex, anode, slow_tick, digit_idx} !== exp_out()) begin
      n_fail++; $display("FAIL reset_release got=%h want=%h", {reg_hex, anode, slow_tick, digit_idx}, exp_out());
    end
  endtask

  task automatic test_idle_scan();
    repeat (2 * FRAME + 3) begin
      cycle();
      n_checks++;
      if ({reg_hex, anode, slow_tick, digit_idx} !== exp_out()) begin
        n_fail++; $display("FAIL idle_scan cyc=%0d got=%h want=%h", m_cyc, {reg_hex, anode, slow_tick, digit_idx}, exp_out());
      end
    end
  endtask

  task automatic test_load_midframe();
    logic [31:0] v;
    int unsigned d;
    v = 32'h1234_ABCD;
    while (m_dig() != 3) cycle();
    disp_value = v; load = 1'b1;
    cycle();
    load = 1'b0; disp_value = $urandom;
    // Until the wrap the old value stays on screen.
    while ((m_cyc % FRAME) != 0) begin
      n_checks++;
      if ({reg_hex, anode, slow_tick, digit_idx} !== exp_out()) begin
        n_fail++; $display("FAIL load_pre_wrap cyc=%0d got=%h want=%h", m_cyc, {reg_hex, anode, slow_tick, digit_idx}, exp_out());
      end
      cycle();
    end
    repeat (FRAME) begin
      d = m_dig();
      n_checks++;
      if (reg_hex !== v[4*d +: 4]) begin
        n_fail++; $display("FAIL load_frame digit=%0d got=%h want=%h", d, reg_hex, v[4*d +: 4]);
      end
      n_checks++;
      if ({reg_hex, anode, slow_tick, digit_idx} !== exp_out()) begin
        n_fail++; $display("FAIL load_frame_model cyc=%0d got=%h want=%h", m_cyc, {reg_hex, anode, slow_tick, digit_idx}, exp_out());
      end
      cycle();
    end
  endtask

  task automatic test_blank_lead();
    logic [31:0] vals [2];
    vals[0] = 32'h0000_00F0;
    vals[1] = 32'h0000_0000;
    blank_lead = 1'b1;
    for (int v = 0; v < 2; v++) begin
      disp_value = vals[v]; load = 1'b1;
      cycle();
      load = 1'b0;
      repeat (2 * FRAME) begin
        cycle();
        n_checks++;
        if ({reg_hex, anode, slow_tick, digit_idx} !== exp_out()) begin
          n_fail++; $display("FAIL blank_lead val=%h cyc=%0d got=%h want=%h", vals[v], m_cyc, {reg_hex, anode, slow_tick, digit_idx}, exp_out());
        end
        if (m_dig() >= 2 && m_shown == vals[v]) begin
          n_checks++;
          if (anode !== 8'hFF) begin
            n_fail++; $display("FAIL blank_lead_off val=%h got=%h want=ff", vals[v], anode);
          end
        end
      end
    end
    blank_lead = 1'b0;
  endtask

  task automatic test_wrap_load();
    int k;
    disp_value = 32'h2222_2222; load = 1'b1;
    cycle();
    load = 1'b0;
    k = 0;
    while (((m_cyc + 1) % FRAME) != 0 && k < int'(FRAME)) begin
      cycle(); k++;
    end
    n_checks++;
    if (((m_cyc + 1) % FRAME) != 0) begin
      n_fail++; $display("FAIL wrap_search cyc=%0d reached=0 want=1", m_cyc);
    end
    disp_value = 32'h1111_1111; load = 1'b1;
    cycle();
    load = 1'b0;
    n_checks++;
    if (reg_hex !== 4'h2) begin
      n_fail++; $display("FAIL wrap_first_frame got=%h want=2", reg_hex);
    end
    repeat (FRAME) begin
      n_checks++;
      if ({reg_hex, anode, slow_tick, digit_idx} !== exp_out()) begin
        n_fail++; $display("FAIL wrap_load cyc=%0d got=%h want=%h", m_cyc, {reg_hex, anode, slow_tick, digit_idx}, exp_out());
      end
      cycle();
    end
    n_checks++;
    if (reg_hex !== 4'h1) begin
      n_fail++; $display("FAIL wrap_second_frame got=%h want=1", reg_hex);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned d1;
    d1 = $urandom_range(1, 3);
    while (m_dig() != d1) cycle();
    disp_value = 32'hAAAA_AAAA; load = 1'b1;
    cycle();
    load = 1'b0;
    while (m_dig() != d1 + 3) cycle();
    disp_value = 32'h5555_5555; load = 1'b1;
    cycle();
    load = 1'b0;
    repeat (2 * FRAME) begin
      cycle();
      n_checks++;
      if ({reg_hex, anode, slow_tick, digit_idx} !== exp_out()) begin
        n_fail++; $display("FAIL back_to_back cyc=%0d got=%h want=%h", m_cyc, {reg_hex, anode, slow_tick, digit_idx}, exp_out());
      end
      if (m_dig() == 0 && m_shown == 32'h5555_5555) begin
        n_checks++;
        if (reg_hex === 4'hA) begin
          n_fail++; $display("FAIL back_to_back_first got=%h want=5", reg_hex);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int k;
    k = 0;
    while (m_dig() != 5 && k < int'(2 * FRAME)) begin cycle(); k++; end
    disp_value = 32'h9876_5432; load = 1'b1;
    cycle();
    load = 1'b0;
    n_checks++;
    if (m_dig() != 5 || !m_pvld) begin
      n_fail++; $display("FAIL reset_mid_setup dig=%0d pvld=%0d want dig=5 pvld=1", m_dig(), m_pvld);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({reg_hex, anode, slow_tick, digit_idx} !== {4'h0, 8'hFF, 1'b0, 3'd0}) begin
      n_fail++; $display("FAIL reset_mid_async got=%h want=%h", {reg_hex, anode, slow_tick, digit_idx}, {4'h0, 8'hFF, 1'b0, 3'd0});
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2 * FRAME + 2) begin
      cycle();
      n_checks++;
      if ({reg_hex, anode, slow_tick, digit_idx} !== exp_out()) begin
        n_fail++; $display("FAIL reset_mid_restart cyc=%0d got=%h want=%h", m_cyc, {reg_hex, anode, slow_tick, digit_idx}, exp_out());
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    repeat (400) begin
      load = ($urandom_range(0, 7) == 0);
      r = $urandom;
      disp_value = r >> (4 * $urandom_range(0, 8));
      if ($urandom_range(0, 31) == 0) blank_lead = ~blank_lead;
      cycle();
      n_checks++;
      if ({reg_hex, anode, slow_tick, digit_idx} !== exp_out()) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", m_cyc, {reg_hex, anode, slow_tick, digit_idx}, exp_out());
      end
    end
    load = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_scan();
    test_load_midframe();
    test_blank_lead();
    test_wrap_load();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "timeout");
  end

endmodule
